output_drain_buffer: RTL and testbench
======================================

// Module: output_drain_buffer
// PURPOSE
//  Collects result rows leaving the bottom of the systolic array and hands them off downstream.
//  The array delivers result lanes skewed: lane k arrives k cycles after lane 0.
//  The block de-skews the lanes into aligned rows, stores them in a FIFO, and drains them
//  over a valid/ready interface. It is the egress counterpart of the input-side FIFO feeding the array.
// PARAMETERS
//  LANES       3   number of result lanes (array columns)
//  ACC_WIDTH   16  bits per lane result
//  ADDR_WIDTH  2   FIFO address bits; depth = 2**ADDR_WIDTH rows
// PORTS
//  i_clk        in   1                clock, all logic on posedge
//  i_rst_n      in   1                synchronous active-low reset
//  i_clear      in   1                synchronous flush; lower priority than reset
//  i_res_valid  in   LANES            per-lane result strobe (skewed)
//  i_res_data   in   LANES*ACC_WIDTH  lane k = bits [k*ACC_WIDTH +: ACC_WIDTH]
//  o_valid      out  1                aligned row available (FIFO not empty)
//  i_ready      in   1                downstream accepts row; pop = o_valid & i_ready
//  o_data       out  LANES*ACC_WIDTH  head row; 0 whenever o_valid=0
//  o_ovf        out  1                sticky: a complete row was dropped because FIFO full
//  o_align_err  out  1                sticky: partial row seen at deskew output
//  o_count      out  ADDR_WIDTH+1     FIFO occupancy (only with OB_STATUS_EN)
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge):
//   - clears pointers, count, delay lines (valid and data), memory, o_ovf and o_align_err.
//   - Outputs: o_valid=0, o_data=0, o_ovf=0, o_align_err=0, o_count=0.
//  Deskew:
//   - lane k passes through (LANES-1-k) registers; lane LANES-1 is unregistered.
//   - Valid bits are delayed alongside data.
//  Row formation on aligned valids av[LANES-1:0], evaluated each cycle:
//   - all ones  -> row write request.
//   - all zeros -> idle.
//   - otherwise -> no write, o_align_err<=1. The partial row is discarded.
//  FIFO, first-word-fall-through:
//   - o_valid = (count != 0); o_data = mem[rd_ptr] when o_valid.
//   - push = wr_req & (!full | pop); pop = o_valid & i_ready.
//   - Push and pop in the same cycle: count unchanged; a full FIFO stays full and accepts the row.
//   - wr_req & full & !pop -> row dropped, o_ovf<=1, no pointer/count change.
//   - Pop when empty is impossible (o_valid=0); i_ready is ignored.
//   - No bypass: a row written into an empty FIFO becomes visible the next cycle.
//   - Pointers wrap modulo 2**ADDR_WIDTH; count saturates at neither end by construction.
//  Latency:
//   - lane 0 valid at cycle t with lanes k at t+k -> o_valid=1 at cycle t+LANES.
//   - Back-to-back rows every cycle are sustained while i_ready=1.
//  i_clear=1 at posedge:
//   - empties FIFO (pointers, count = 0) and zeroes delay-line valids.
//   - clears o_ovf and o_align_err.
//   - Input arriving in the same cycle is discarded; memory contents need not clear.
//  Reset mid-stream: all in-flight lanes and stored rows are lost; no partial row is emitted afterwards.
// CONFIGURATION
//  OB_STATUS_EN defined:
//   - o_count port exists and equals current occupancy (0..2**ADDR_WIDTH), registered.
//  OB_STATUS_EN undefined:
//   - o_count port is absent; full/empty come from pointer wrap bits. Other behaviour is identical.
// TESTING (LANES=3, ACC_WIDTH=16, ADDR_WIDTH=2)
//  1. Reset then idle 5 cycles -> o_valid=0, o_data=0, flags 0, o_count=0.
//  2. Skewed row: lane0=0x0011@t, lane1=0x0022@t+1, lane2=0x0033@t+2, i_ready=0
//     -> o_valid=1 at t+3, o_data=0x0033_0022_0011, o_count=1.
//  3. 5 consecutive skewed rows, i_ready=0 -> first 4 stored (o_count=4), 5th dropped, o_ovf=1;
//     then i_ready=1 drains rows 1..4 in order; o_ovf stays 1 until i_clear.
//  4. FIFO full, i_ready=1, new row arriving in the same cycle -> row accepted; o_count stays 4; o_ovf stays 0.
//  5. Lane1 valid missing for one row -> no write, o_align_err=1, next complete row stored normally.
//  6. 2 rows stored, assert i_clear (then i_rst_n=0 in a separate run)
//     -> next cycle o_valid=0, o_count=0, flags 0; a fresh row appears after 3 cycles.

Source files
------------

// File: rtl/output_drain_buffer.sv
// output_drain_buffer
//   Egress buffer for the systolic array. Result lanes arrive skewed (lane k lags lane 0 by
//   k cycles). They are realigned into rows, queued in a first-word-fall-through FIFO and
//   drained over a valid/ready handshake.
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_rst_n      synchronous active-low reset
//   i_clear      synchronous flush of FIFO, delay-line valids and sticky flags
//   i_res_valid  per-lane result strobe (skewed)
//   i_res_data   per-lane result data, lane k = [k*ACC_WIDTH +: ACC_WIDTH]
//   i_ready      downstream accepts the head row
//   o_valid      head row available
//   o_data       head row, zero when o_valid is low
//   o_ovf        sticky: a complete row was dropped because the FIFO was full
//   o_align_err  sticky: a partial row appeared at the deskew output
//   o_count      FIFO occupancy (present only when OB_STATUS_EN is defined)
//
// Configuration
//   OB_STATUS_EN  defined: adds the registered o_count occupancy port.
module output_drain_buffer #(
    parameter int unsigned LANES      = 3,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic [LANES-1:0]           i_res_valid,
    input  logic [LANES*ACC_WIDTH-1:0] i_res_data,
    input  logic                       i_ready,
`ifdef OB_STATUS_EN
    output logic [ADDR_WIDTH:0]        o_count,
`endif
    output logic                       o_valid,
    output logic [LANES*ACC_WIDTH-1:0] o_data,
    output logic                       o_ovf,
    output logic                       o_align_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned ROW_W = LANES * ACC_WIDTH;

    // Aligned lane valids and data at the deskew output
    logic [LANES-1:0] w_av;
    logic [ROW_W-1:0] w_ad;

    // Lane k is delayed by LANES-1-k registers so all lanes of a row line up
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned D = LANES - 1 - k;
        if (D == 0) begin : g_pass
            assign w_av[k]                         = i_res_valid[k];
            assign w_ad[k*ACC_WIDTH +: ACC_WIDTH] = i_res_data[k*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [D-1:0]                r_v;
            logic [D-1:0][ACC_WIDTH-1:0] r_d;
            // Register chain plus the new sample; the top element is the delayed tap
            logic [D:0]                  w_vcat;
            logic [D:0][ACC_WIDTH-1:0]   w_dcat;

            assign w_vcat = {r_v, i_res_valid[k]};
            assign w_dcat = {r_d, i_res_data[k*ACC_WIDTH +: ACC_WIDTH]};

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_v <= '0;
                    r_d <= '0;
                end else if (i_clear) begin
                    // Data may keep stale values; only valids gate row formation
                    r_v <= '0;
                end else begin
                    r_v <= w_vcat[D-1:0];
                    r_d <= w_dcat[D-1:0];
                end
            end

            assign w_av[k]                         = w_vcat[D];
            assign w_ad[k*ACC_WIDTH +: ACC_WIDTH] = w_dcat[D];
        end
    end

    logic [ROW_W-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic                r_ovf;
    logic                r_align_err;

    logic w_wr_req;
    logic w_partial;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_wr_req  = &w_av;
    assign w_partial = (|w_av) & ~(&w_av);

    // Extra pointer MSB distinguishes full from empty when the addresses match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    assign w_pop  = ~w_empty & i_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle
    assign w_push = w_wr_req & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ovf       <= 1'b0;
            r_align_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ovf       <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_ad;
                r_wr_ptr                        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_partial) begin
                r_align_err <= 1'b1;
            end
        end
    end

`ifdef OB_STATUS_EN
    logic [ADDR_WIDTH:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
`endif

    assign o_valid     = ~w_empty;
    assign o_data      = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign o_ovf       = r_ovf;
    assign o_align_err = r_align_err;

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed bench for output_drain_buffer (LANES=3, ACC_WIDTH=16, ADDR_WIDTH=2).
module tb_output_drain_buffer;

    localparam int unsigned LANES      = 3;
    localparam int unsigned ACC_WIDTH  = 16;
    localparam int unsigned ADDR_WIDTH = 2;
    localparam int unsigned ROW_W      = LANES * ACC_WIDTH;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_clear;
    logic [LANES-1:0]    i_res_valid;
    logic [ROW_W-1:0]    i_res_data;
    logic                i_ready;
    logic                o_valid;
    logic [ROW_W-1:0]    o_data;
    logic                o_ovf;
    logic                o_align_err;
`ifdef OB_STATUS_EN
    logic [ADDR_WIDTH:0] o_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    output_drain_buffer #(
        .LANES      (LANES),
        .ACC_WIDTH  (ACC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_clear),
        .i_res_valid (i_res_valid),
        .i_res_data  (i_res_data),
        .i_ready     (i_ready),
`ifdef OB_STATUS_EN
        .o_count     (o_count),
`endif
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_ovf       (o_ovf),
        .o_align_err (o_align_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge; outputs are stable from here on
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [ACC_WIDTH-1:0] lane_val(input int row, input int k);
        return ACC_WIDTH'((k + 1) * 17 + row * 256);
    endfunction

    function automatic logic [ROW_W-1:0] row_data(input int row);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k*ACC_WIDTH +: ACC_WIDTH] = lane_val(row, k);
        end
        return r;
    endfunction

    // Drive n skewed rows starting at cycle 0; row r lane k appears at cycle r+k.
    // skip_row/skip_lane removes one lane strobe; i_ready is 1 only at cycle rdy_cycle.
    task automatic send_rows(input int n, input int first, input int skip_row,
                             input int skip_lane, input int rdy_cycle);
        for (int c = 0; c < n + LANES - 1; c++) begin
            i_res_valid = '0;
            i_res_data  = '0;
            i_ready     = (c == rdy_cycle);
            for (int k = 0; k < LANES; k++) begin
                int r;
                r = c - k;
                if (r >= 0 && r < n && !(r == skip_row && k == skip_lane)) begin
                    i_res_valid[k]                         = 1'b1;
                    i_res_data[k*ACC_WIDTH +: ACC_WIDTH] = lane_val(first + r, k);
                end
            end
            tick();
        end
        i_res_valid = '0;
        i_res_data  = '0;
        i_ready     = 1'b0;
    endtask

    task automatic drain_expect(input string tag, input int row);
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_data"}, 64'(o_data), 64'(row_data(row)));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_clear     = 1'b0;
        i_res_valid = '0;
        i_res_data  = '0;
        i_ready     = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;

        // 1: idle after reset
        repeat (5) tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        check("rst_align", 64'(o_align_err), 64'd0);
`ifdef OB_STATUS_EN
        check("rst_count", 64'(o_count), 64'd0);
`endif

        // 2: one skewed row, latency LANES cycles
        i_res_valid = 3'b001;
        i_res_data  = 48'h0000_0000_0011;
        tick();
        i_res_valid = 3'b010;
        i_res_data  = 48'h0000_0022_0000;
        check("lat_t1_valid", 64'(o_valid), 64'd0);
        tick();
        i_res_valid = 3'b100;
        i_res_data  = 48'h0033_0000_0000;
        check("lat_t2_valid", 64'(o_valid), 64'd0);
        tick();
        i_res_valid = '0;
        i_res_data  = '0;
        check("lat_t3_valid", 64'(o_valid), 64'd1);
        check("lat_t3_data", 64'(o_data), 64'h0033_0022_0011);
`ifdef OB_STATUS_EN
        check("lat_count", 64'(o_count), 64'd1);
`endif
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("lat_pop_valid", 64'(o_valid), 64'd0);
        check("lat_pop_data", 64'(o_data), 64'd0);

        // 3: five rows into a four-deep FIFO, fifth dropped
        send_rows(5, 0, -1, 0, -1);
        check("ovf_flag", 64'(o_ovf), 64'd1);
`ifdef OB_STATUS_EN
        check("ovf_count", 64'(o_count), 64'd4);
`endif
        for (int i = 0; i < 4; i++) drain_expect("ovf_drain", i);
        check("ovf_empty", 64'(o_valid), 64'd0);
        check("ovf_sticky", 64'(o_ovf), 64'd1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("ovf_cleared", 64'(o_ovf), 64'd0);

        // 4: full FIFO with simultaneous pop accepts the incoming row
        send_rows(5, 10, -1, 0, 6);
        check("full_pp_ovf", 64'(o_ovf), 64'd0);
`ifdef OB_STATUS_EN
        check("full_pp_count", 64'(o_count), 64'd4);
`endif
        for (int i = 11; i < 15; i++) drain_expect("full_pp_drain", i);
        check("full_pp_empty", 64'(o_valid), 64'd0);

        // 5: lane 1 missing for the middle row
        send_rows(3, 20, 1, 1, -1);
        check("align_flag", 64'(o_align_err), 64'd1);
`ifdef OB_STATUS_EN
        check("align_count", 64'(o_count), 64'd2);
`endif
        drain_expect("align_r0", 20);
        drain_expect("align_r2", 22);
        check("align_empty", 64'(o_valid), 64'd0);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;

        // 6a: flush with two rows stored and a flag set
        send_rows(3, 30, 2, 0, -1);
        check("clr_pre_valid", 64'(o_valid), 64'd1);
        check("clr_pre_align", 64'(o_align_err), 64'd1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_valid", 64'(o_valid), 64'd0);
        check("clr_data", 64'(o_data), 64'd0);
        check("clr_align", 64'(o_align_err), 64'd0);
        check("clr_ovf", 64'(o_ovf), 64'd0);
`ifdef OB_STATUS_EN
        check("clr_count", 64'(o_count), 64'd0);
`endif
        send_rows(1, 40, -1, 0, -1);
        drain_expect("clr_fresh", 40);

        // 6b: reset with two rows stored
        send_rows(3, 50, 2, 0, -1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check("rst2_valid", 64'(o_valid), 64'd0);
        check("rst2_data", 64'(o_data), 64'd0);
        check("rst2_align", 64'(o_align_err), 64'd0);
`ifdef OB_STATUS_EN
        check("rst2_count", 64'(o_count), 64'd0);
`endif

        // Reset while a row is in flight: no partial row may surface later
        i_res_valid = 3'b001;
        i_res_data  = 48'h0000_0000_0abc;
        tick();
        i_rst_n     = 1'b0;
        i_res_valid = 3'b010;
        i_res_data  = 48'h0000_0def_0000;
        tick();
        i_rst_n     = 1'b1;
        i_res_valid = '0;
        i_res_data  = '0;
        repeat (4) tick();
        check("rst_mid_align", 64'(o_align_err), 64'd0);
        check("rst_mid_valid", 64'(o_valid), 64'd0);
        send_rows(1, 60, -1, 0, -1);
        drain_expect("rst_fresh", 60);
        check("end_empty", 64'(o_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
